// File: rtl/affine_transform_pipe_if.sv
// ----------------------------------------------------------------------------
// affine_transform_pipe_if
// Handshake bundle for the affine transform pipe.
//   in_valid/in_ready/in_data/in_mode  : upstream transaction channel
//   out_valid/out_ready/out_data/out_mode : downstream result channel
//   err   : sticky reserved-mode flag
//   count : number of results currently buffered (0..2)
// The slave modport is the pipe itself; the master modport is whatever
// drives transactions in and accepts results out.
// ----------------------------------------------------------------------------
interface affine_transform_pipe_if #(
    parameter int NUM_BYTES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [8*NUM_BYTES-1:0] in_data;
    logic [1:0]             in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*NUM_BYTES-1:0] out_data;
    logic [1:0]             out_mode;
    logic                   err;
    logic [1:0]             count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, err, count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, err, count
    );
endinterface

// File: rtl/affine_transform_pipe.sv
// ----------------------------------------------------------------------------
// affine_transform_pipe
// Applies a per-byte GF(2) affine transform (forward, inverse or bypass) to
// every lane of an incoming transaction and buffers the results in a
// 2-entry in-order FIFO.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, flushes the FIFO and clears err
//   bus  : affine_transform_pipe_if.slave (in/out handshake, err, count)
// Mode encoding: 00 bypass, 01 forward affine, 10 inverse affine,
// 11 reserved (lanes forced to zero, err set).
// ----------------------------------------------------------------------------
module affine_transform_pipe #(
    parameter int         NUM_BYTES = 16,
    parameter logic [7:0] AFF_CONST = 8'h63,
    parameter logic [7:0] INV_CONST = 8'h05
) (
    input  logic                          clk,
    input  logic                          rst,
    affine_transform_pipe_if.slave        bus
);

    localparam int W = 8 * NUM_BYTES;

    // Forward affine on one byte. A 3-bit index wraps mod 8 by itself.
    function automatic logic [7:0] fwd_byte(input logic [7:0] b);
        logic [7:0] y;
        logic [2:0] idx;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            idx    = 3'(i);
            y[idx] = b[idx] ^ b[idx + 3'd4] ^ b[idx + 3'd5] ^ b[idx + 3'd6] ^ b[idx + 3'd7];
        end
        return y ^ AFF_CONST;
    endfunction

    // Inverse affine on one byte.
    function automatic logic [7:0] inv_byte(input logic [7:0] b);
        logic [7:0] y;
        logic [2:0] idx;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            idx    = 3'(i);
            y[idx] = b[idx + 3'd2] ^ b[idx + 3'd5] ^ b[idx + 3'd7];
        end
        return y ^ INV_CONST;
    endfunction

    // Whole-transaction transform; lanes never mix.
    function automatic logic [W-1:0] transform(input logic [W-1:0] data,
                                               input logic [1:0]   mode);
        logic [W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            case (mode)
                2'b00:   res[8*k +: 8] = data[8*k +: 8];
                2'b01:   res[8*k +: 8] = fwd_byte(data[8*k +: 8]);
                2'b10:   res[8*k +: 8] = inv_byte(data[8*k +: 8]);
                default: res[8*k +: 8] = 8'h00;
            endcase
        end
        return res;
    endfunction

    logic [1:0]   count_q,   count_d;
    logic         wr_ptr_q,  wr_ptr_d;
    logic         rd_ptr_q,  rd_ptr_d;
    logic         err_q,     err_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] data_q [2];
    logic [W-1:0] data_d [2];
    logic [1:0]   mode_q [2];
    logic [1:0]   mode_d [2];
    logic         push;
    logic         pop;

    // Next-state logic. The transform happens at push time, so the FIFO
    // holds finished results. in_ready is registered from the next count,
    // which keeps out_ready off the in_ready path and means a pop at full
    // cannot open the input in the same cycle.
    always_comb begin
        push       = bus.in_valid && in_ready_q;
        pop        = (count_q != 2'd0) && bus.out_ready;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        data_d     = data_q;
        mode_d     = mode_q;

        if (push) begin
            data_d[wr_ptr_q] = transform(bus.in_data, bus.in_mode);
            mode_d[wr_ptr_q] = bus.in_mode;
            wr_ptr_d         = ~wr_ptr_q;
            if (bus.in_mode == 2'b11) begin
                err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d != 2'd2);
    end

    // State registers; reset flushes everything and holds in_ready low
    // until the first edge after rst deasserts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            mode_q[0]  <= 2'b00;
            mode_q[1]  <= 2'b00;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
        end
    end

    // Outputs come straight from state; an empty FIFO drives zeros.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = (count_q != 2'd0) ? data_q[rd_ptr_q] : '0;
    assign bus.out_mode  = (count_q != 2'd0) ? mode_q[rd_ptr_q] : 2'b00;
    assign bus.err       = err_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_affine_transform_pipe.sv
// ----------------------------------------------------------------------------
// tb_affine_transform_pipe
// Scoreboard bench for affine_transform_pipe (16 lanes, default constants).
// Stimulus pushes the expected result into a queue when a transaction is
// accepted; an independent monitor pops and compares on every output pop.
// ----------------------------------------------------------------------------
module tb_affine_transform_pipe;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    affine_transform_pipe_if #(.NUM_BYTES(NB)) bus ();

    affine_transform_pipe #(
        .NUM_BYTES(NB),
        .AFF_CONST(8'h63),
        .INV_CONST(8'h05)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    // Reference lane model written with rotations, independent of the
    // bit-index form in the design.
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [W-1:0] model_fwd(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            b = x[8*k +: 8];
            r[8*k +: 8] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        return r;
    endfunction

    // Monitor: compare every popped result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_vectors++;
                if (sb_q.size() == 0) begin
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_output got data=%h mode=%0d, expected no output",
                             bus.out_data, bus.out_mode);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (bus.out_data !== mon_e.data || bus.out_mode !== mon_e.mode) begin
                        n_miscompares++;
                        $display("[TB] FAIL out_result got data=%h mode=%0d, expected data=%h mode=%0d",
                                 bus.out_data, bus.out_mode, mon_e.data, mon_e.mode);
                    end
                end
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer one transaction (called just after a rising edge); the expected
    // result is queued in the cycle the DUT accepts it. Idle inputs are
    // driven with junk and mode 11 to show they are ignored without a push.
    task automatic applyStimulus(input logic [W-1:0] data, input logic [1:0] mode,
                                 input logic [W-1:0] exp_data);
        exp_t e;
        bit   accepted;
        accepted    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_mode  = mode;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.data   = exp_data;
                e.mode   = mode;
                sb_q.push_back(e);
                accepted = 1'b1;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        bus.in_mode  = 2'b11;
        if (!accepted) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL accept_timeout got no in_ready, expected acceptance");
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 100) begin
            step();
            c++;
        end
        checkOutput("drain_empty", W'(sb_q.size()), W'(0));
    endtask

    logic [7:0]   fin  [5] = '{8'h00, 8'hCA, 8'h01, 8'hFF, 8'h80};
    logic [7:0]   fout [5] = '{8'h63, 8'hED, 8'h7C, 8'h9C, 8'hEC};
    logic [W-1:0] mix_in, mix_out, x;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_count",     W'(bus.count),     W'(0));
        checkOutput("rst_in_ready",  W'(bus.in_ready),  W'(0));
        checkOutput("rst_out_valid", W'(bus.out_valid), W'(0));
        checkOutput("rst_out_data",  bus.out_data,      W'(0));
        checkOutput("rst_out_mode",  W'(bus.out_mode),  W'(0));
        checkOutput("rst_err",       W'(bus.err),       W'(0));
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        checkOutput("in_ready_after_rst", W'(bus.in_ready), W'(1));
        step();

        // Forward vectors, with the one-cycle latency into an empty FIFO
        bus.out_ready = 1'b1;
        applyStimulus({NB{8'h00}}, 2'b01, {NB{8'h63}});
        @(negedge clk);
        checkOutput("latency_out_valid", W'(bus.out_valid), W'(1));
        step();
        applyStimulus({NB{8'hCA}}, 2'b01, {NB{8'hED}});
        applyStimulus({NB{8'h01}}, 2'b01, {NB{8'h7C}});
        for (int k = 0; k < NB; k++) begin
            mix_in[8*k +: 8]  = fin[k % 5];
            mix_out[8*k +: 8] = fout[k % 5];
        end
        applyStimulus(mix_in, 2'b01, mix_out);

        // Inverse vectors
        applyStimulus({NB{8'h63}}, 2'b10, {NB{8'h00}});
        applyStimulus({NB{8'hED}}, 2'b10, {NB{8'hCA}});
        applyStimulus({NB{8'h7C}}, 2'b10, {NB{8'h01}});
        applyStimulus(mix_out, 2'b10, mix_in);

        // Random forward-then-inverse round trips
        for (int r = 0; r < 4; r++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(x, 2'b01, model_fwd(x));
            applyStimulus(model_fwd(x), 2'b10, x);
        end
        drain();

        // Backpressure: A then B held, then released in order
        bus.out_ready = 1'b0;
        applyStimulus({NB{8'h3C}}, 2'b00, {NB{8'h3C}});
        applyStimulus({NB{8'h00}}, 2'b01, {NB{8'h63}});
        @(negedge clk);
        checkOutput("bp_count_full",  W'(bus.count),    W'(2));
        checkOutput("bp_in_ready",    W'(bus.in_ready), W'(0));
        checkOutput("bp_data_a",      bus.out_data,     {NB{8'h3C}});
        step();
        step();
        @(negedge clk);
        checkOutput("bp_data_a_hold", bus.out_data,     {NB{8'h3C}});
        checkOutput("bp_mode_a_hold", W'(bus.out_mode), W'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_count_2", W'(bus.count), W'(2));
        step();
        @(negedge clk);
        checkOutput("bp_count_1", W'(bus.count), W'(1));
        step();
        @(negedge clk);
        checkOutput("bp_count_0", W'(bus.count), W'(0));
        step();

        // Simultaneous push and pop at count 1
        bus.out_ready = 1'b0;
        applyStimulus({NB{8'h11}}, 2'b00, {NB{8'h11}});
        bus.out_ready = 1'b1;
        applyStimulus({NB{8'h22}}, 2'b00, {NB{8'h22}});
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("sim_count_1", W'(bus.count), W'(1));
        checkOutput("sim_data_c",  bus.out_data,  {NB{8'h22}});
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        checkOutput("sim_count_0", W'(bus.count), W'(0));
        step();

        // Full with a pop: the input stays closed in that cycle
        bus.out_ready = 1'b0;
        applyStimulus({NB{8'h44}}, 2'b00, {NB{8'h44}});
        applyStimulus({NB{8'h55}}, 2'b00, {NB{8'h55}});
        bus.in_valid  = 1'b1;
        bus.in_data   = {NB{8'h66}};
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("full_pop_in_ready", W'(bus.in_ready), W'(0));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("full_pop_count", W'(bus.count), W'(1));
        step();
        drain();

        // Bypass and reserved mode with sticky err
        applyStimulus({NB{8'h5A}}, 2'b00, {NB{8'h5A}});
        @(negedge clk);
        checkOutput("err_after_bypass", W'(bus.err), W'(0));
        step();
        applyStimulus({NB{8'hA5}}, 2'b11, W'(0));
        @(negedge clk);
        checkOutput("err_after_reserved", W'(bus.err), W'(1));
        step();
        applyStimulus({NB{8'h01}}, 2'b01, {NB{8'h7C}});
        step();
        @(negedge clk);
        checkOutput("err_sticky", W'(bus.err), W'(1));
        step();
        drain();

        // Reset mid-stream discards queued results
        bus.out_ready = 1'b0;
        applyStimulus({NB{8'h77}}, 2'b00, {NB{8'h77}});
        applyStimulus({NB{8'h88}}, 2'b00, {NB{8'h88}});
        @(negedge clk);
        checkOutput("pre_rst_count", W'(bus.count), W'(2));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checkOutput("mid_rst_count",     W'(bus.count),     W'(0));
        checkOutput("mid_rst_out_valid", W'(bus.out_valid), W'(0));
        checkOutput("mid_rst_err",       W'(bus.err),       W'(0));
        checkOutput("mid_rst_out_data",  bus.out_data,      W'(0));
        step();
        @(negedge clk);
        checkOutput("mid_rst_in_ready", W'(bus.in_ready), W'(1));
        step();
        bus.out_ready = 1'b1;
        repeat (5) step();
        applyStimulus({NB{8'h00}}, 2'b01, {NB{8'h63}});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
